// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// - 4-bit ALU operation codes, shared with the ALU control unit.
// - FSM state encoding for the multicycle shifter.
// - is_shift(): true for the ops that run iteratively (SLL/SRL).
package alu_pkg;

  localparam logic [3:0] ALU_LUI     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_SLL     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_SRL     = 4'b0100;
  localparam logic [3:0] ALU_SUB     = 4'b0101;
  localparam logic [3:0] ALU_AND     = 4'b0110;
  localparam logic [3:0] ALU_NOR     = 4'b0111;
  localparam logic [3:0] ALU_DEFAULT = 4'b1001;  // control-unit default, illegal here

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_logic_core.sv
// Combinational single-cycle ALU ops: LUI, OR, ADD, SUB, AND, NOR.
// Shift codes return 0 with illegal=0 (the top handles shifts itself);
// any other unknown code returns 0 with illegal=1.
// Ports:
//   op      : 4-bit ALU operation code
//   a, b    : operands
//   result  : op result, modulo 2**DATA_WIDTH
//   illegal : op code is not a defined ALU operation
module alu_logic_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  localparam int HALF = DATA_WIDTH / 2;

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      ALU_LUI:          result = {b[HALF-1:0], {HALF{1'b0}}};
      ALU_OR:           result = a | b;
      ALU_ADD:          result = a + b;
      ALU_SUB:          result = a - b;
      ALU_AND:          result = a & b;
      ALU_NOR:          result = ~(a | b);
      ALU_SLL, ALU_SRL: result = '0;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_multicycle_exec.sv
// Execute-stage ALU with start/ready/done handshake.
// Logical/arithmetic ops complete in one cycle; SLL/SRL shift one bit per
// cycle through a working register so no barrel shifter is needed.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start_i           : request, accepted when ready_o=1
//   alu_operation_i   : 4-bit op code (see alu_pkg)
//   a_i, b_i, shamt_i : operands, latched on accept
//   ready_o           : can accept start_i this cycle (IDLE or DONE)
//   done_o            : one-cycle pulse, result/zero/illegal valid
//   result_o, zero_o, illegal_o : registered outputs, held until next update
module alu_multicycle_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,  // must be even
  parameter int SHAMT_WIDTH = 5    // 2**SHAMT_WIDTH <= DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   zero_o,
  output logic                   illegal_o
);

  state_e                 state, state_nx;
  logic [DATA_WIDTH-1:0]  work;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   dir_right;

  logic [DATA_WIDTH-1:0]  core_res;
  logic                   core_ill;
  logic                   accept, load_shift, last_shift;
  logic [DATA_WIDTH-1:0]  one_res, shift_step;

  alu_logic_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .op      (alu_operation_i),
    .a       (a_i),
    .b       (b_i),
    .result  (core_res),
    .illegal (core_ill)
  );

  always_comb begin
    state_nx   = state;
    ready_o    = (state != ST_SHIFT);
    done_o     = (state == ST_DONE);
    accept     = start_i && ready_o;
    // a zero-length shift is just a pass-through of b, done in one cycle
    load_shift = accept && is_shift(alu_operation_i) && (shamt_i != '0);
    one_res    = is_shift(alu_operation_i) ? b_i : core_res;
    shift_step = dir_right ? (work >> 1) : (work << 1);
    // cnt is never 0 while in SHIFT, so 1 marks the final step
    last_shift = (state == ST_SHIFT) && (cnt == SHAMT_WIDTH'(1));

    if (accept) begin
      state_nx = load_shift ? ST_SHIFT : ST_DONE;
    end else begin
      case (state)
        ST_SHIFT: if (last_shift) state_nx = ST_DONE;
        ST_DONE:  state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      work      <= '0;
      cnt       <= '0;
      dir_right <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b1;
      illegal_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_shift) begin
        work      <= b_i;
        cnt       <= shamt_i;
        dir_right <= (alu_operation_i == ALU_SRL);
      end else if (accept) begin
        result_o  <= one_res;
        zero_o    <= (one_res == '0);
        illegal_o <= core_ill;
      end else if (state == ST_SHIFT) begin
        work <= shift_step;
        cnt  <= cnt - SHAMT_WIDTH'(1);
        if (last_shift) begin
          result_o  <= shift_step;
          zero_o    <= (shift_step == '0);
          illegal_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle_exec.sv
module tb_alu_multicycle_exec;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [3:0]    alu_operation_i;
  logic [DW-1:0] a_i, b_i;
  logic [SW-1:0] shamt_i;
  logic          ready_o, done_o, zero_o, illegal_o;
  logic [DW-1:0] result_o;

  alu_multicycle_exec #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .alu_operation_i(alu_operation_i), .a_i(a_i), .b_i(b_i), .shamt_i(shamt_i),
    .ready_o(ready_o), .done_o(done_o), .result_o(result_o),
    .zero_o(zero_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] res;
    logic          z;
    logic          ill;
    int            cyc;
    string         name;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: cyc %0d result %h, no op outstanding", cyc, result_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (result_o !== e.res || zero_o !== e.z || illegal_o !== e.ill || cyc != e.cyc) begin
          n_err++;
          $display("FAIL %s: got res %h z %b ill %b cyc %0d, want res %h z %b ill %b cyc %0d",
                   e.name, result_o, zero_o, illegal_o, cyc, e.res, e.z, e.ill, e.cyc);
        end
      end
    end
  end

  // issue one op; returns #1 after the accepting edge with start_i low
  task automatic issue(input string name, input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [SW-1:0] sh,
                       input logic [DW-1:0] res, input logic ill, input int lat);
    int w = 0;
    exp_t e;
    while (ready_o !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (ready_o !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL %s_ready_timeout: ready_o %b want 1", name, ready_o);
    end
    start_i = 1'b1; alu_operation_i = op; a_i = a; b_i = b; shamt_i = sh;
    e.res = res; e.z = (res == '0); e.ill = ill; e.cyc = cyc + lat; e.name = name;
    q.push_back(e);
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = $urandom; b_i = $urandom; shamt_i = SW'($urandom);  // latched, so scramble
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(posedge clk); #1; w++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; alu_operation_i = '0; a_i = '0; b_i = '0; shamt_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_zero", zero_o, 1);
    chk("rst_illegal", illegal_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    issue("add_5_7", ALU_ADD, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1);
    @(negedge clk);
    chk("add_ready_in_done", ready_o, 1);
    @(posedge clk); #1;
    issue("sub_eq", ALU_SUB, 32'h3, 32'h3, 5'd0, 32'h0, 1'b0, 1);
    issue("lui", ALU_LUI, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0, 1);
    issue("sub_wrap", ALU_SUB, 32'h0, 32'h1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1);
    issue("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1);
    issue("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 1'b0, 1);
    issue("nor_zero", ALU_NOR, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1);
    drain();

    // SLL by 4: ready low for 4 cycles; a start pulse mid-shift is ignored
    issue("sll_4", ALU_SLL, 32'h0, 32'h1, 5'd4, 32'h10, 1'b0, 5);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        start_i = 1'b1; alu_operation_i = ALU_ADD; a_i = 32'd1; b_i = 32'd1;
      end
      @(negedge clk);
      chk($sformatf("sll_ready_low_%0d", i), ready_o, 0);
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    drain();

    issue("srl_31", ALU_SRL, 32'h0, 32'h8000_0000, 5'd31, 32'h1, 1'b0, 32);
    drain();
    issue("sll_0", ALU_SLL, 32'h0, 32'h0000_ABCD, 5'd0, 32'h0000_ABCD, 1'b0, 1);
    drain();

    // illegal then back-to-back OR in the DONE cycle
    issue("illegal", ALU_DEFAULT, 32'h55, 32'hAA, 5'd0, 32'h0, 1'b1, 1);
    issue("or_b2b", ALU_OR, 32'hF0, 32'h0F, 5'd0, 32'hFF, 1'b0, 1);
    drain();

    // reset 3 cycles into a 20-bit shift: aborts with no done pulse
    q.push_back('{res: 32'h0, z: 1'b0, ill: 1'b0, cyc: -1, name: "sentinel"});
    void'(q.pop_back());
    begin
      start_i = 1'b1; alu_operation_i = ALU_SLL; b_i = 32'h1; shamt_i = 5'd20;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", ready_o, 1);
    chk("abort_result", result_o, 0);
    chk("abort_zero", zero_o, 1);
    chk("abort_done", done_o, 0);
    repeat (25) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
